totient_seq_ctrl: RTL and testbench

- Sequencer for the Euler-totient seven-segment display datapath.
- Owns the index n and steps it through 1..N_MAX and back in a ping-pong pattern, holding each endpoint for two dwell intervals.
- Advances are paced either by a free-running prescaler (run mode) or by a single-step push (step mode).
- Drives a registered phi(n) value and the ABCDEFG segment lines, so the display datapath becomes a pure consumer of this block.

---
 rtl/totient_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_totient_seq_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/totient_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | totient_seq_ctrl: ping-pong index sequencer with registered phi(n) and      |
// | seven-segment outputs for the Euler-totient display.                        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module totient_seq_ctrl #(
  parameter int DWELL = 2,
  parameter int N_MAX = 16
) (
  input  logic       clk_0,
  input  logic       R,
  input  logic       run,
  input  logic       step,
  output logic [4:0] n,
  output logic [3:0] phi,
  output logic       dir,
  output logic       turn,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic       F,
  output logic       G
);

  localparam int              c_cnt_w    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DWELL - 1);
  localparam logic [4:0]      c_n_max    = 5'(N_MAX);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_fwd  = 2'd1;
  localparam logic [1:0] c_rev  = 2'd2;

  logic [1:0]         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_step_q;
  logic [4:0]         r_n;
  logic [3:0]         r_phi;
  logic               r_dir;
  logic               r_turn;
  logic [6:0]         r_seg;

  logic               w_adv;
  logic [1:0]         w_state;
  logic [4:0]         w_n;
  logic               w_dir;
  logic               w_turn;
  logic [3:0]         w_phi;
  logic [6:0]         w_seg;

  function automatic logic [3:0] phi_rom(input logic [4:0] idx);
    case (idx)
      5'd1:    phi_rom = 4'd1;
      5'd2:    phi_rom = 4'd1;
      5'd3:    phi_rom = 4'd2;
      5'd4:    phi_rom = 4'd2;
      5'd5:    phi_rom = 4'd4;
      5'd6:    phi_rom = 4'd2;
      5'd7:    phi_rom = 4'd6;
      5'd8:    phi_rom = 4'd4;
      5'd9:    phi_rom = 4'd6;
      5'd10:   phi_rom = 4'd4;
      5'd11:   phi_rom = 4'd10;
      5'd12:   phi_rom = 4'd4;
      5'd13:   phi_rom = 4'd12;
      5'd14:   phi_rom = 4'd6;
      5'd15:   phi_rom = 4'd8;
      5'd16:   phi_rom = 4'd8;
      default: phi_rom = 4'd0;
    endcase
  endfunction

  // Bit 6 is segment A, bit 0 is segment G.
  function automatic logic [6:0] seg_rom(input logic [3:0] v);
    case (v)
      4'h0:    seg_rom = 7'b1111110;
      4'h1:    seg_rom = 7'b0110000;
      4'h2:    seg_rom = 7'b1101101;
      4'h3:    seg_rom = 7'b1111001;
      4'h4:    seg_rom = 7'b0110011;
      4'h5:    seg_rom = 7'b1011011;
      4'h6:    seg_rom = 7'b1011111;
      4'h7:    seg_rom = 7'b1110000;
      4'h8:    seg_rom = 7'b1111111;
      4'h9:    seg_rom = 7'b1111011;
      4'hA:    seg_rom = 7'b1110111;
      4'hB:    seg_rom = 7'b0011111;
      4'hC:    seg_rom = 7'b1001110;
      4'hD:    seg_rom = 7'b0111101;
      4'hE:    seg_rom = 7'b1001111;
      default: seg_rom = 7'b1000111;
    endcase
  endfunction

  // Step edges are ignored while running; the edge register still tracks step.
  always_comb begin
    if (run) w_adv = (r_cnt == c_cnt_last);
    else     w_adv = step & ~r_step_q;
  end

  always_comb begin
    w_state = r_state;
    w_n     = r_n;
    w_dir   = r_dir;
    w_turn  = 1'b0;
    if (w_adv) begin
      case (r_state)
        c_idle: w_state = c_fwd;
        c_fwd: begin
          if (r_n < c_n_max) begin
            w_n = r_n + 5'd1;
          end else begin
            w_state = c_rev;
            w_dir   = 1'b1;
            w_turn  = 1'b1;
          end
        end
        c_rev: begin
          if (r_n > 5'd1) begin
            w_n = r_n - 5'd1;
          end else begin
            w_state = c_fwd;
            w_dir   = 1'b0;
            w_turn  = 1'b1;
          end
        end
        default: w_state = c_idle;
      endcase
    end
    w_phi = phi_rom(w_n);
    w_seg = seg_rom(w_phi);
  end

  always_ff @(posedge clk_0 or negedge R) begin
    if (!R) begin
      r_cnt    <= '0;
      r_step_q <= 1'b0;
    end else begin
      r_step_q <= step;
      if (!run || (r_cnt == c_cnt_last)) r_cnt <= '0;
      else                               r_cnt <= r_cnt + 1'b1;
    end
  end

  // Display registers load from the next index so they change with n.
  always_ff @(posedge clk_0 or negedge R) begin
    if (!R) begin
      r_state <= c_idle;
      r_n     <= 5'd1;
      r_phi   <= 4'd1;
      r_dir   <= 1'b0;
      r_turn  <= 1'b0;
      r_seg   <= 7'b0110000;
    end else begin
      r_state <= w_state;
      r_n     <= w_n;
      r_phi   <= w_phi;
      r_dir   <= w_dir;
      r_turn  <= w_turn;
      r_seg   <= w_seg;
    end
  end

  assign n    = r_n;
  assign phi  = r_phi;
  assign dir  = r_dir;
  assign turn = r_turn;
  assign {A, B, C, D, E, F, G} = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_totient_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_totient_seq_ctrl: scoreboard bench, four parameter sets on shared inputs.|
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_totient_seq_ctrl;

  localparam int NCFG = 4;

  typedef struct packed {
    logic [4:0] n;
    logic [3:0] phi;
    logic       dir;
    logic       turn;
    logic [6:0] seg;
  } exp_t;

  logic clk_0;
  logic R;
  logic run;
  logic step;

  logic [4:0] n_w    [NCFG];
  logic [3:0] phi_w  [NCFG];
  logic       dir_w  [NCFG];
  logic       turn_w [NCFG];
  logic [6:0] seg_w  [NCFG];

  int vectors = 0;
  int misc    = 0;

  initial clk_0 = 1'b0;
  always #5 clk_0 = ~clk_0;

  function automatic int gcd(input int a, input int b);
    int x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = y;
      y = x % y;
      x = t;
    end
    return x;
  endfunction

  function automatic int totient(input int v);
    int c;
    c = 0;
    for (int k = 1; k <= v; k++)
      if (gcd(k, v) == 1) c++;
    return c;
  endfunction

  function automatic logic [6:0] hex_seg(input int v);
    case (v)
      0: return 7'h7E;  1: return 7'h30;  2: return 7'h6D;  3: return 7'h79;
      4: return 7'h33;  5: return 7'h5B;  6: return 7'h5F;  7: return 7'h70;
      8: return 7'h7F;  9: return 7'h7B; 10: return 7'h77; 11: return 7'h1F;
      12: return 7'h4E; 13: return 7'h3D; 14: return 7'h4F; default: return 7'h47;
    endcase
  endfunction

  // One lap is 1..nm then nm..1: 2*nm positions, endpoints appear twice.
  function automatic exp_t expect_of(input bit idle, input int idx, input int nm, input bit trn);
    exp_t e;
    int v, p;
    v = idle ? 1 : ((idx < nm) ? idx + 1 : 2 * nm - idx);
    p = totient(v);
    e.n    = 5'(v);
    e.phi  = 4'(p);
    e.dir  = idle ? 1'b0 : (idx >= nm);
    e.turn = trn;
    e.seg  = hex_seg(p);
    return e;
  endfunction

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int DW = (gi == 0) ? 2 : (gi == 1) ? 1 : (gi == 2) ? 4 : 1;
    localparam int NM = (gi == 3) ? 5 : 16;

    logic [4:0] dn;
    logic [3:0] dphi;
    logic       ddir, dturn;
    logic       sa, sb, sc, sd, se, sf, sg;

    totient_seq_ctrl #(.DWELL(DW), .N_MAX(NM)) u_dut (
      .clk_0(clk_0), .R(R), .run(run), .step(step),
      .n(dn), .phi(dphi), .dir(ddir), .turn(dturn),
      .A(sa), .B(sb), .C(sc), .D(sd), .E(se), .F(sf), .G(sg)
    );

    assign n_w[gi]    = dn;
    assign phi_w[gi]  = dphi;
    assign dir_w[gi]  = ddir;
    assign turn_w[gi] = dturn;
    assign seg_w[gi]  = {sa, sb, sc, sd, se, sf, sg};

    exp_t q[$];
    int   m_cnt = 0;
    int   m_idx = 0;
    bit   m_idle = 1'b1;
    bit   m_prev = 1'b0;
    bit   m_turn = 1'b0;
    bit   m_adv;

    always @(posedge clk_0 or negedge R) begin
      if (!R) begin
        m_cnt  = 0;
        m_idx  = 0;
        m_idle = 1'b1;
        m_prev = 1'b0;
        m_turn = 1'b0;
        if (clk_0) q.push_back(expect_of(m_idle, m_idx, NM, m_turn));
      end else begin
        m_adv  = run ? (m_cnt == DW - 1) : (step && !m_prev);
        m_cnt  = (run && m_cnt < DW - 1) ? m_cnt + 1 : 0;
        m_prev = step;
        m_turn = 1'b0;
        if (m_adv) begin
          if (m_idle) begin
            m_idle = 1'b0;
            m_idx  = 0;
          end else begin
            m_idx  = (m_idx + 1) % (2 * NM);
            m_turn = (m_idx == NM) || (m_idx == 0);
          end
        end
        q.push_back(expect_of(m_idle, m_idx, NM, m_turn));
      end
    end

    always @(negedge clk_0) begin
      exp_t a, e;
      a = {dn, dphi, ddir, dturn, sa, sb, sc, sd, se, sf, sg};
      vectors++;
      if (q.size() == 0) begin
        misc++;
        $display("FAIL cfg%0d no_expected at %0t: got n=%0d", gi, $time, dn);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          misc++;
          $display("FAIL cfg%0d outputs at %0t: got n=%0d phi=%0d dir=%b turn=%b seg=%b, want n=%0d phi=%0d dir=%b turn=%b seg=%b",
                   gi, $time, a.n, a.phi, a.dir, a.turn, a.seg, e.n, e.phi, e.dir, e.turn, e.seg);
        end
      end
    end
  end

  task automatic check_reset_now(input string tag);
    for (int i = 0; i < NCFG; i++) begin
      vectors++;
      if (n_w[i] !== 5'd1 || phi_w[i] !== 4'd1 || dir_w[i] !== 1'b0 ||
          turn_w[i] !== 1'b0 || seg_w[i] !== 7'b0110000) begin
        misc++;
        $display("FAIL cfg%0d reset_%s at %0t: got n=%0d phi=%0d dir=%b turn=%b seg=%b, want n=1 phi=1 dir=0 turn=0 seg=0110000",
                 i, tag, $time, n_w[i], phi_w[i], dir_w[i], turn_w[i], seg_w[i]);
      end
    end
  endtask

  // Called just after a falling edge: R low for 3 of the 5 units before the rise.
  task automatic pulse_reset();
    #1 R = 1'b0;
    #2 check_reset_now("async");
    #1 R = 1'b1;
  endtask

  initial begin
    bit found;
    R    = 1'b0;
    run  = 1'b1;
    step = 1'b0;
    repeat (3) @(negedge clk_0);
    check_reset_now("held");
    R = 1'b1;

    repeat (70) @(negedge clk_0);

    run = 1'b0;
    repeat (2) @(negedge clk_0);
    for (int k = 0; k < 4; k++) begin
      step = 1'b1;
      repeat (3) @(negedge clk_0);
      step = 1'b0;
      repeat (2) @(negedge clk_0);
    end

    run = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step = ~step;
      @(negedge clk_0);
    end
    step = 1'b1;
    repeat (2) @(negedge clk_0);
    run = 1'b0;
    repeat (3) @(negedge clk_0);
    step = 1'b0;
    @(negedge clk_0);
    step = 1'b1;
    repeat (2) @(negedge clk_0);
    step = 1'b0;

    run   = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk_0);
      if (n_w[1] == 5'd13 && dir_w[1] == 1'b1) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      misc++;
      $display("FAIL wait_n13_desc: got timeout, want cfg1 at n=13 descending");
    end
    pulse_reset();
    repeat (40) @(negedge clk_0);

    for (int k = 0; k < 3000; k++) begin
      if (k % 20 == 0) run = ($urandom_range(0, 2) != 0);
      step = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 249) == 0) pulse_reset();
      @(negedge clk_0);
    end

    repeat (2) @(negedge clk_0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
`default_nettype wire
